// File: rtl/fp16_to_fp8_packer.sv
// Collects byte-serial FP16 words, converts each to FP8 E4M3 (RNE, saturation, subnormals)
// and queues the results in a small FIFO behind a valid/ready byte interface.
//
//   state | meaning
//   LO    | waiting for the low byte of the next FP16 word
//   HI    | low byte held, waiting for the high byte
module fp16_to_fp8_packer #(
   parameter int FIFO_DEPTH = 4,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            clr,
   input  logic [7:0]                      in_byte,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [7:0]                      out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            sat_sticky,
   output logic                            nan_sticky,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {LO = 1'b0, HI = 1'b1} phase_t;

   phase_t         phase;
   logic           rst_q;
   logic [7:0]     lo_byte;
   logic [15:0]    stage_word;
   logic           stage_valid;
   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [LW-1:0]  count;

   logic           push;
   logic           pop;
   logic           accept;
   logic [7:0]     conv_byte;
   logic           conv_sat;
   logic           conv_nan;

   // Stage slot is reserved against FIFO space so a staged word can always be pushed.
   assign in_ready   = rst_q && ((count + LW'(stage_valid)) < LW'(FIFO_DEPTH));
   assign accept     = in_valid && in_ready;
   assign out_valid  = (count != '0);
   assign out_data   = out_valid ? mem[rd_ptr] : 8'h00;
   assign fifo_level = count;
   assign push       = rst_n && !clr && stage_valid;
   assign pop        = out_valid && out_ready;

   // FP16 -> E4M3 conversion of the staged word
   always_comb begin
      logic       s;
      logic [4:0] e;
      logic [9:0] m;
      logic [5:0] ef;
      logic [5:0] ef_r;
      logic [2:0] mant;
      logic [3:0] mant4;
      logic       up;
      logic       ovf;
      logic [2:0] k;
      logic [17:0] t;
      logic       up_s;
      logic [3:0] r4;

      s     = stage_word[15];
      e     = stage_word[14:10];
      m     = stage_word[9:0];
      ef    = {1'b0, e} - 6'd8;
      mant  = m[9:7];
      up    = m[6] && ((|m[5:0]) || mant[0]);
      mant4 = {1'b0, mant} + {3'b000, up};
      ef_r  = ef + {5'b00000, mant4[3]};
      k     = 3'(5'd8 - e);
      t     = {1'b1, m, 7'b0000000} >> k;
      up_s  = t[14] && ((|t[13:0]) || t[15]);
      r4    = {1'b0, t[17:15]} + {3'b000, up_s};
      ovf   = 1'b0;

      conv_byte = {s, 7'h00};
      conv_sat  = 1'b0;
      conv_nan  = 1'b0;

      if (e == 5'd31) begin
         if (m != '0) begin
            conv_byte = {s, 7'h7F};
            conv_nan  = 1'b1;
         end else begin
            ovf = 1'b1;
         end
      end else if (e == 5'd0) begin
         conv_byte = {s, 7'h00};
      end else if (e >= 5'd9) begin
         if ((ef_r > 6'd15) || ((ef_r == 6'd15) && (mant4[2:0] == 3'b111)))
            ovf = 1'b1;
         else
            conv_byte = {s, ef_r[3:0], mant4[2:0]};
      end else begin
         // r4 == 8 lands exactly on the minimum normal encoding
         conv_byte = {s, 3'b000, r4};
      end

      if (ovf) begin
         conv_byte = SATURATE ? {s, 7'h7E} : {s, 7'h7F};
         conv_sat  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rst_q       <= 1'b0;
         phase       <= LO;
         lo_byte     <= 8'h00;
         stage_word  <= 16'h0000;
         stage_valid <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         sat_sticky  <= 1'b0;
         nan_sticky  <= 1'b0;
      end else begin
         rst_q <= 1'b1;
         if (clr) begin
            phase       <= LO;
            stage_valid <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
         end else begin
            stage_valid <= 1'b0;
            if (accept) begin
               case (phase)
                  LO: begin
                     lo_byte <= in_byte;
                     phase   <= HI;
                  end
                  HI: begin
                     stage_word  <= {in_byte, lo_byte};
                     stage_valid <= 1'b1;
                     phase       <= LO;
                  end
                  default: phase <= LO;
               endcase
            end
            if (push) begin
               wr_ptr     <= wr_ptr + AW'(1);
               sat_sticky <= sat_sticky | conv_sat;
               nan_sticky <= nan_sticky | conv_nan;
            end
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(push) - LW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= conv_byte;
   end

endmodule

// File: tb/tb_fp16_to_fp8_packer.sv
// Directed bench for fp16_to_fp8_packer; a SATURATE=0 copy runs on the same stimulus.
module tb_fp16_to_fp8_packer;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic [7:0] in_byte;
   logic       in_valid;
   logic       out_ready;

   logic       in_ready,   in_ready_ns;
   logic [7:0] out_data,   out_data_ns;
   logic       out_valid,  out_valid_ns;
   logic       sat_sticky, sat_sticky_ns;
   logic       nan_sticky, nan_sticky_ns;
   logic [2:0] fifo_level, fifo_level_ns;

   int n_cmp = 0;
   int n_err = 0;

   fp16_to_fp8_packer #(.FIFO_DEPTH(4), .SATURATE(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_byte(in_byte), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .sat_sticky(sat_sticky), .nan_sticky(nan_sticky), .fifo_level(fifo_level));

   fp16_to_fp8_packer #(.FIFO_DEPTH(4), .SATURATE(1'b0)) u_dut_ns (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_byte(in_byte), .in_valid(in_valid),
      .in_ready(in_ready_ns), .out_data(out_data_ns), .out_valid(out_valid_ns), .out_ready(out_ready),
      .sat_sticky(sat_sticky_ns), .nan_sticky(nan_sticky_ns), .fifo_level(fifo_level_ns));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int waited;
      waited   = 0;
      in_byte  = b;
      in_valid = 1'b1;
      while (!in_ready && waited < 50) begin
         step();
         waited++;
      end
      chk("in_ready_wait", 8'(in_ready), 8'h01);
      step();
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] lo, input logic [7:0] hi);
      send_byte(lo);
      send_byte(hi);
   endtask

   task automatic expect_out(input string tag, input logic [7:0] exp, input logic [7:0] exp_ns);
      int waited;
      waited = 0;
      while (!out_valid && waited < 50) begin
         step();
         waited++;
      end
      chk({tag, "_valid"}, 8'(out_valid), 8'h01);
      chk(tag, out_data, exp);
      chk({tag, "_ns"}, out_data_ns, exp_ns);
      step();
   endtask

   initial begin
      logic [7:0] drain_exp [3];
      drain_exp[0] = 8'h44;
      drain_exp[1] = 8'h48;
      drain_exp[2] = 8'h4A;

      rst_n     = 1'b0;
      clr       = 1'b0;
      in_byte   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();
      chk("rst_out_data",  out_data,          8'h00);
      chk("rst_out_valid", 8'(out_valid),     8'h00);
      chk("rst_in_ready",  8'(in_ready),      8'h00);
      chk("rst_sat",       8'(sat_sticky),    8'h00);
      chk("rst_nan",       8'(nan_sticky),    8'h00);
      chk("rst_level",     8'(fifo_level),    8'h00);
      rst_n = 1'b1;
      step();
      chk("post_rst_in_ready", 8'(in_ready), 8'h01);

      // 1.0: latency check around the high-byte accept edge
      send_word(8'h00, 8'h3C);
      chk("lat_e0_valid", 8'(out_valid), 8'h00);
      step();
      chk("lat_e1_valid", 8'(out_valid), 8'h01);
      chk("lat_e1_data",  out_data,      8'h38);
      step();
      chk("lat_e2_valid", 8'(out_valid), 8'h00);
      chk("lat_e2_level", 8'(fifo_level), 8'h00);

      send_word(8'h00, 8'hC0); expect_out("neg2",      8'hC0, 8'hC0);
      send_word(8'h40, 8'h3C); expect_out("tie_even",  8'h38, 8'h38);
      send_word(8'hC0, 8'h3C); expect_out("tie_odd",   8'h3A, 8'h3A);
      send_word(8'h00, 8'h5F); expect_out("max448",    8'h7E, 8'h7E);
      chk("sat_after_448", 8'(sat_sticky), 8'h00);
      send_word(8'hD0, 8'h5F); expect_out("ovf500",    8'h7E, 8'h7F);
      chk("sat_after_500", 8'(sat_sticky), 8'h01);
      chk("sat_ns_500",    8'(sat_sticky_ns), 8'h01);
      send_word(8'h00, 8'h7C); expect_out("pinf",      8'h7E, 8'h7F);
      chk("nan_before", 8'(nan_sticky), 8'h00);
      send_word(8'h00, 8'h7E); expect_out("nan",       8'h7F, 8'h7F);
      chk("nan_after", 8'(nan_sticky), 8'h01);
      send_word(8'h00, 8'h18); expect_out("sub_2m9",   8'h01, 8'h01);
      send_word(8'h00, 8'h20); expect_out("sub_2m7",   8'h04, 8'h04);
      send_word(8'h01, 8'h00); expect_out("fp16_sub",  8'h00, 8'h00);
      send_word(8'h00, 8'hA0); expect_out("neg_2m7",   8'h84, 8'h84);

      // Backpressure: fill FIFO with out_ready low
      out_ready = 1'b0;
      send_word(8'h00, 8'h3C);
      send_word(8'h00, 8'h40);
      send_word(8'h00, 8'h42);
      send_word(8'h00, 8'h44);
      chk("full_in_ready_a", 8'(in_ready), 8'h00);
      step();
      chk("full_level",      8'(fifo_level), 8'h04);
      chk("full_in_ready_b", 8'(in_ready),   8'h00);
      in_byte  = 8'h00;
      in_valid = 1'b1;
      step();
      chk("full_hold_level", 8'(fifo_level), 8'h04);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("head0", out_data, 8'h38);
      step();
      out_ready = 1'b0;
      chk("pop1_level",    8'(fifo_level), 8'h03);
      chk("pop1_in_ready", 8'(in_ready),   8'h01);
      chk("head1",         out_data,       8'h40);
      send_word(8'h00, 8'h45);
      chk("w5_in_ready", 8'(in_ready), 8'h00);
      out_ready = 1'b1;
      step();
      chk("pushpop_level", 8'(fifo_level), 8'h03);
      for (int i = 0; i < 3; i++) begin
         chk("drain_valid", 8'(out_valid), 8'h01);
         chk("drain_data",  out_data,      drain_exp[i]);
         step();
      end
      chk("drain_empty", 8'(out_valid),  8'h00);
      chk("drain_level", 8'(fifo_level), 8'h00);

      // clr drops a dangling low byte, keeps stickies
      send_byte(8'h00);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_sat_kept", 8'(sat_sticky), 8'h01);
      chk("clr_nan_kept", 8'(nan_sticky), 8'h01);
      send_word(8'h00, 8'h3C); expect_out("after_clr", 8'h38, 8'h38);

      // reset mid-word
      send_byte(8'h00);
      rst_n = 1'b0;
      step();
      chk("rst2_sat", 8'(sat_sticky), 8'h00);
      chk("rst2_nan", 8'(nan_sticky), 8'h00);
      rst_n = 1'b1;
      step();
      send_word(8'h00, 8'h3C); expect_out("after_rst", 8'h38, 8'h38);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
